sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL provide parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL provide parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE (default 16).
REQ-003 SHALL provide parameter AF_THRESH, default 14, almost-full level, 1..DEPTH-1.
REQ-004 SHALL provide parameter AE_THRESH, default 2, almost-empty level, 1..DEPTH-1.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: winc  in  1  write request; wdata  in  DSIZE  write data; rinc  in  1  read request.
REQ-007 SHALL have ports: rdata  out  DSIZE  read data; wfull  out  1  full; rempty  out  1  empty.
REQ-008 SHALL have ports: almost_full  out  1; almost_empty  out  1; count  out  ASIZE+1  occupancy.
REQ-009 SHALL have ports: overflow  out  1  sticky; underflow  out  1  sticky; err_clr  in  1  clears sticky errors.

Function
REQ-010 SHALL store data in a DEPTH x DSIZE register array with ASIZE+1-bit write and read pointers wrapping modulo 2*DEPTH.
REQ-011 SHALL accept a write at a clk edge iff winc=1 and wfull=0: mem[wptr]<=wdata, wptr+1.
REQ-012 SHALL accept a read at a clk edge iff rinc=1 and rempty=0: rptr+1.
REQ-013 SHALL base acceptance on flags sampled before the edge; winc while full is refused even with a simultaneous accepted read.
REQ-014 SHALL update count as registered: +1 write only, -1 read only, unchanged for both or neither.
REQ-015 SHALL decode flags from registered count: wfull = (count==DEPTH), rempty = (count==0).
REQ-016 SHALL assert almost_full when count>=AF_THRESH and almost_empty when count<=AE_THRESH.
REQ-017 SHALL set overflow on the edge where winc=1 and wfull=1; no write occurs and data is dropped.
REQ-018 SHALL set underflow on the edge where rinc=1 and rempty=1; no pointer change occurs.
REQ-019 SHALL clear overflow/underflow on the edge where err_clr=1, except a same-edge set wins.
REQ-020 SHALL, with the FWFT macro undefined, register rdata<=mem[rptr] on an accepted read, hold it otherwise (latency 1 cycle).
REQ-021 SHALL keep storage order strict FIFO across pointer wrap-around; no word is lost or duplicated.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously clear wptr, rptr, count, overflow, underflow; registered rdata SHALL reset to 0.
REQ-023 SHALL, during and directly after reset, output rempty=1, wfull=0, almost_empty=1, almost_full=0, count=0.
REQ-024 SHALL not reset memory contents; reset mid-operation discards all stored words.

Configuration
REQ-025 SHALL support macro SYNC_FIFO_FWFT_EN; when defined, rdata = mem[rptr] combinationally whenever rempty=0 (first-word fall-through), rinc pops, rdata is 0 when rempty=1.
REQ-026 SHALL, with SYNC_FIFO_FWFT_EN undefined, behave per REQ-020; flags, count and errors are identical in both modes.

Verification
REQ-027 Reset, then 16 writes of 0..15 -> wfull=1 after 16th edge, count=16, almost_full from count=14, overflow=0.
REQ-028 Full FIFO, winc=1 with wdata=8'hAA plus rinc=1 for one cycle -> read accepted, write refused, overflow=1, count=15.
REQ-029 16 reads after REQ-027 -> rdata sequence 0..15 (1-cycle latency non-FWFT), rempty=1 after last, almost_empty from count=2.
REQ-030 Empty FIFO, rinc=1 -> underflow=1, count=0; err_clr=1 next cycle -> underflow=0.
REQ-031 Half-full (8), winc=rinc=1 for 40 cycles with ramp data -> count stays 8, output order preserved across two wraps.
REQ-032 SYNC_FIFO_FWFT_EN defined, write 8'h5C to empty -> next cycle rempty=0, rdata=8'h5C before rinc; rst_n pulse mid-stream -> count=0, rempty=1 immediately.

Source files
------------

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count, almost flags and sticky errors
// Optional macro SYNC_FIFO_FWFT_EN selects first-word fall-through read data.
module sync_fifo #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT   = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_CNT   = (ASIZE+1)'(AE_THRESH);
    localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_en;
    logic             rd_en;

    // Flags come from the registered count, so acceptance uses pre-edge state.
    assign wfull        = (count == FULL_CNT);
    assign rempty       = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_en = winc && !wfull;
    assign rd_en = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + ONE;
            end
            if (rd_en) begin
                rptr <= rptr + ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // A set on the same edge as err_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[rptr[ASIZE-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - table-driven self-checking bench for sync_fifo (default, non-FWFT build)
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    typedef struct {
        logic       w;
        logic [7:0] wd;
        logic       r;
        logic       clr;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic [7:0] rd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic w, input logic [7:0] wd, input logic r, input logic clr,
                                input int cnt, input logic ovf, input logic udf, input logic [7:0] rd);
        vec_t v;
        v.w = w; v.wd = wd; v.r = r; v.clr = clr;
        v.cnt   = 5'(cnt);
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        v.ovf = ovf; v.udf = udf; v.rd = rd;
        vq.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [7:0] rd);
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".wfull"}, 32'(wfull), 32'(cnt == 16));
        check({tag, ".rempty"}, 32'(rempty), 32'(cnt == 0));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= 14));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
        check({tag, ".rdata"}, 32'(rdata), 32'(rd));
    endtask

    task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic clr);
        winc = w; wdata = wd; rinc = r; err_clr = clr;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = '0; rinc = 1'b0; err_clr = 1'b0;

        // Fill 0..15, overflow with simultaneous read, drain, then error/flag corners.
        for (int i = 0; i < 16; i++) add(1'b1, 8'(i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 8'hAA, 1'b1, 1'b0, 15, 1'b1, 1'b0, 8'h00);
        add(1'b0, 8'h00, 1'b0, 1'b1, 15, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i < 16; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 15 - i, 1'b0, 1'b0, 8'(i));
        add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h0F);
        add(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h0F);
        add(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'h0F);
        add(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h0F);
        add(1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'h0F);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h0F);
        add(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h33);

        repeat (2) @(posedge clk);
        #1;
        check_state("in_reset", 0, 8'h00);
        check("in_reset.overflow", 32'(overflow), 32'd0);
        check("in_reset.underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_reset", 0, 8'h00);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].w, vq[i].wd, vq[i].r, vq[i].clr);
            check($sformatf("row%0d.count", i), 32'(count), 32'(vq[i].cnt));
            check($sformatf("row%0d.wfull", i), 32'(wfull), 32'(vq[i].full));
            check($sformatf("row%0d.rempty", i), 32'(rempty), 32'(vq[i].empty));
            check($sformatf("row%0d.almost_full", i), 32'(almost_full), 32'(vq[i].af));
            check($sformatf("row%0d.almost_empty", i), 32'(almost_empty), 32'(vq[i].ae));
            check($sformatf("row%0d.overflow", i), 32'(overflow), 32'(vq[i].ovf));
            check($sformatf("row%0d.underflow", i), 32'(underflow), 32'(vq[i].udf));
            check($sformatf("row%0d.rdata", i), 32'(rdata), 32'(vq[i].rd));
        end

        // Half-full streaming across two pointer wraps.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
        check_state("half_full", 8, 8'h33);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'(108 + k), 1'b1, 1'b0);
            check($sformatf("stream%0d.count", k), 32'(count), 32'd8);
            check($sformatf("stream%0d.rdata", k), 32'(rdata), 32'(100 + k));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("drain%0d.rdata", k), 32'(rdata), 32'(140 + k));
        end
        check_state("drained", 0, 8'(147));
        check("drained.overflow", 32'(overflow), 32'd0);
        check("drained.underflow", 32'(underflow), 32'd0);

        // Asynchronous reset mid-stream discards stored words.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(200 + i), 1'b0, 1'b0);
        check_state("pre_reset", 3, 8'(147));
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_reset", 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset", 0, 8'h00);
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        check_state("post_reset_wr", 1, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("post_reset_rd", 0, 8'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
